i2s_rx: RTL and testbench

I2S slave receiver that captures serial audio data from the codec ADC into parallel left/right samples in the system `clk` domain. It is the receive-side counterpart of the I2S transmitter that drives `DToDAC`. The codec supplies `Wclk` and `Bclk`, both treated as asynchronous data inputs, and `Mclk = clk`. Completed stereo frames go to the SPI glue logic through a valid/ready handshake.

---
 rtl/i2s_rx_if.sv | 26 ++
 rtl/i2s_rx.sv | 150 +++++++++++++++
 tb/tb_i2s_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// Bus bundle for the I2S receiver: codec-side serial pins plus the frame
// valid/ready handshake towards the SPI glue logic.
interface i2s_rx_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              Wclk;
    logic              Bclk;
    logic              i2s_in;
    logic [DATA_W-1:0] DLeft;
    logic [DATA_W-1:0] DRight;
    logic              valid;
    logic              ready;
    logic              overrun;
    logic              overrun_clr;
    logic [7:0]        debug;

    modport slave (
        input  Wclk, Bclk, i2s_in, ready, overrun_clr,
        output DLeft, DRight, valid, overrun, debug
    );

    modport master (
        output Wclk, Bclk, i2s_in, ready, overrun_clr,
        input  DLeft, DRight, valid, overrun, debug
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples Wclk/Bclk/data in the clk domain and emits stereo frames.
// Optional registered debug bus enabled by defining I2S_RX_DEBUG_EN; DATA_W must not exceed 63.
module i2s_rx #(
    parameter int unsigned DATA_W = 16
) (
    input  logic    clk,
    input  logic    reset_n,
    i2s_rx_if.slave bus_io
);
    localparam logic [0:0] StSync = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [1:0]        wclk_sync_q;
    logic [2:0]        bclk_sync_q;
    logic [1:0]        sd_sync_q;
    logic              rise_q, ws_q, sd_q;
    logic [0:0]        state_q, state_d;
    logic              ws_prev_q, ws_prev_d;
    logic              left_ok_q, left_ok_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] left_stage_q, left_stage_d;
    logic [DATA_W-1:0] dleft_q, dleft_d;
    logic [DATA_W-1:0] dright_q, dright_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] sh_wr;
    logic              frame_done;

    // ws/sd are registered alongside the edge pulse so all three stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wclk_sync_q <= '0;
            bclk_sync_q <= '0;
            sd_sync_q   <= '0;
            rise_q      <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
        end else begin
            wclk_sync_q <= {wclk_sync_q[0], bus_io.Wclk};
            bclk_sync_q <= {bclk_sync_q[1:0], bus_io.Bclk};
            sd_sync_q   <= {sd_sync_q[0], bus_io.i2s_in};
            rise_q      <= bclk_sync_q[1] & ~bclk_sync_q[2];
            ws_q        <= wclk_sync_q[1];
            sd_q        <= sd_sync_q[1];
        end
    end

    always_comb begin
        state_d      = state_q;
        ws_prev_d    = ws_prev_q;
        left_ok_d    = left_ok_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        left_stage_d = left_stage_q;
        dleft_d      = dleft_q;
        dright_d     = dright_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        frame_done   = 1'b0;

        sh_wr = shreg_q;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (cnt_q == 6'(int'(DATA_W) - 1 - i)) sh_wr[i] = sd_q;
        end

        if (valid_q && bus_io.ready) valid_d = 1'b0;

        if (rise_q) begin
            if (state_q == StSync) begin
                if (ws_q != ws_prev_q) begin
                    state_d   = StRun;
                    ws_prev_d = ws_q;
                    cnt_d     = '0;
                    shreg_d   = '0;
                end
            end else if (ws_q != ws_prev_q) begin
                ws_prev_d = ws_q;
                cnt_d     = '0;
                shreg_d   = '0;
                if (!ws_prev_q) begin
                    left_stage_d = sh_wr;
                    left_ok_d    = 1'b1;
                end else if (left_ok_q) begin
                    // A right word without a preceding full left word is a partial frame.
                    frame_done = 1'b1;
                end
            end else begin
                shreg_d = sh_wr;
                if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
            end
        end

        if (frame_done) begin
            dleft_d  = left_stage_q;
            dright_d = sh_wr;
            valid_d  = 1'b1;
        end

        if (frame_done && valid_q && !bus_io.ready) begin
            overrun_d = 1'b1;
        end else if (bus_io.overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StSync;
            ws_prev_q    <= 1'b0;
            left_ok_q    <= 1'b0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            left_stage_q <= '0;
            dleft_q      <= '0;
            dright_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ws_prev_q    <= ws_prev_d;
            left_ok_q    <= left_ok_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            left_stage_q <= left_stage_d;
            dleft_q      <= dleft_d;
            dright_q     <= dright_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus_io.DLeft   = dleft_q;
    assign bus_io.DRight  = dright_q;
    assign bus_io.valid   = valid_q;
    assign bus_io.overrun = overrun_q;

`ifdef I2S_RX_DEBUG_EN
    logic [7:0] debug_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) debug_q <= 8'h00;
        else          debug_q <= {state_q, ws_prev_q, valid_q, overrun_q, cnt_q[3:0]};
    end

    assign bus_io.debug = debug_q;
`else
    assign bus_io.debug = 8'h00;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: codec-style serial stimulus, table of frames, handshake corner cases.
module tb_i2s_rx;
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          n;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   valid_cycles = 0;
    logic vclr;
    logic dbg_bad = 1'b0;
    vec_t vecs[6];

    i2s_rx_if #(.DATA_W(16)) bus ();

    i2s_rx #(.DATA_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vclr) valid_cycles <= 0;
        else if (bus.valid === 1'b1) valid_cycles <= valid_cycles + 1;
        if (bus.debug !== 8'h00) dbg_bad <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One Bclk period of 4 clk: data changes while Bclk is low.
    task automatic send_bit(input logic ws, input logic sd);
        @(negedge clk);
        bus.Bclk   = 1'b0;
        bus.Wclk   = ws;
        bus.i2s_in = sd;
        wait_neg(2);
        bus.Bclk = 1'b1;
        wait_neg(1);
    endtask

    // Word on channel ws; its last bit carries the toggled ws (I2S one-bit delay).
    task automatic send_word(input logic ws, input logic [15:0] val, input int n,
                             input int from, input int upto);
        for (int j = from; j < upto; j++) begin
            send_bit((j == n - 1) ? ~ws : ws, (j < 16) ? val[15 - j] : 1'b1);
        end
    endtask

    task automatic idle_and_clear();
        @(negedge clk);
        bus.Bclk = 1'b0;
        wait_neg(8);
    endtask

    task automatic clear_vcnt();
        @(negedge clk);
        vclr = 1'b1;
        @(negedge clk);
        vclr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 16, 16'h1234, 16'h5678};
        vecs[1] = '{16'hAACC, 16'hF502, 32, 16'hAACC, 16'hF502};
        vecs[2] = '{16'hABCF, 16'h567F, 12, 16'hABC0, 16'h5670};
        vecs[3] = '{16'hBEEF, 16'h0F0F, 40, 16'hBEEF, 16'h0F0F};
        vecs[4] = '{16'h8000, 16'hFFFF,  1, 16'h8000, 16'h8000};
        vecs[5] = '{16'hC3A5, 16'h3C5A, 63, 16'hC3A5, 16'h3C5A};

        reset_n         = 1'b0;
        vclr            = 1'b1;
        bus.Wclk        = 1'b1;
        bus.Bclk        = 1'b0;
        bus.i2s_in      = 1'b0;
        bus.ready       = 1'b1;
        bus.overrun_clr = 1'b0;
        wait_neg(3);
        check("reset_dleft", 32'(bus.DLeft), 32'h0);
        check("reset_dright", 32'(bus.DRight), 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_overrun", 32'(bus.overrun), 32'h0);
        check("reset_debug", 32'(bus.debug), 32'h0);

        // Reset released in the middle of a right word: that word must not form a frame.
        send_word(1'b1, 16'hFFFF, 16, 0, 6);
        @(negedge clk);
        reset_n = 1'b1;
        vclr    = 1'b0;
        send_word(1'b1, 16'hFFFF, 16, 6, 16);
        idle_and_clear();
        check("partial_no_frame", 32'(valid_cycles), 32'd0);

        for (int k = 0; k < 6; k++) begin
            clear_vcnt();
            send_word(1'b0, vecs[k].l, vecs[k].n, 0, vecs[k].n);
            send_word(1'b1, vecs[k].r, vecs[k].n, 0, vecs[k].n);
            idle_and_clear();
            check($sformatf("v%0d_dleft", k), 32'(bus.DLeft), 32'(vecs[k].exp_l));
            check($sformatf("v%0d_dright", k), 32'(bus.DRight), 32'(vecs[k].exp_r));
            check($sformatf("v%0d_valid_pulse", k), 32'(valid_cycles), 32'd1);
            check($sformatf("v%0d_valid_low", k), 32'(bus.valid), 32'h0);
            check($sformatf("v%0d_overrun", k), 32'(bus.overrun), 32'h0);
        end

        // Two frames with no consumer: second replaces first and raises overrun.
        bus.ready = 1'b0;
        send_word(1'b0, 16'h0001, 16, 0, 16);
        send_word(1'b1, 16'h0002, 16, 0, 16);
        idle_and_clear();
        check("hold_valid", 32'(bus.valid), 32'h1);
        check("hold_overrun0", 32'(bus.overrun), 32'h0);
        send_word(1'b0, 16'h0003, 16, 0, 16);
        send_word(1'b1, 16'h0004, 16, 0, 16);
        idle_and_clear();
        check("ovr_valid", 32'(bus.valid), 32'h1);
        check("ovr_dleft", 32'(bus.DLeft), 32'h0003);
        check("ovr_dright", 32'(bus.DRight), 32'h0004);
        check("ovr_flag", 32'(bus.overrun), 32'h1);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("ovr_cleared", 32'(bus.overrun), 32'h0);
        check("ovr_clr_valid", 32'(bus.valid), 32'h1);

        // Accept in exactly the commit cycle: 4 clk edges after the last Bclk rise.
        send_word(1'b0, 16'h0005, 16, 0, 16);
        send_word(1'b1, 16'h0006, 16, 0, 15);
        @(negedge clk);
        bus.Bclk   = 1'b0;
        bus.Wclk   = 1'b0;
        bus.i2s_in = 1'b0;
        wait_neg(2);
        bus.Bclk = 1'b1;
        wait_neg(3);
        check("pre_commit_old", 32'(bus.DLeft), 32'h0003);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check("same_cycle_valid", 32'(bus.valid), 32'h1);
        check("same_cycle_dleft", 32'(bus.DLeft), 32'h0005);
        check("same_cycle_dright", 32'(bus.DRight), 32'h0006);
        check("same_cycle_overrun", 32'(bus.overrun), 32'h0);
        bus.ready = 1'b1;
        @(negedge clk);
        check("accept_valid_low", 32'(bus.valid), 32'h0);

        // Asynchronous reset mid-left-word.
        send_word(1'b0, 16'hDEAD, 16, 0, 8);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset_dleft", 32'(bus.DLeft), 32'h0);
        check("areset_dright", 32'(bus.DRight), 32'h0);
        check("areset_valid", 32'(bus.valid), 32'h0);
        check("areset_overrun", 32'(bus.overrun), 32'h0);
        wait_neg(3);
        reset_n = 1'b1;
        clear_vcnt();
        send_word(1'b0, 16'hDEAD, 16, 8, 16);
        send_word(1'b1, 16'hBEEF, 16, 0, 16);
        idle_and_clear();
        check("after_reset_no_frame", 32'(valid_cycles), 32'd0);
        send_word(1'b0, 16'hCAFE, 16, 0, 16);
        send_word(1'b1, 16'h1357, 16, 0, 16);
        idle_and_clear();
        check("after_reset_dleft", 32'(bus.DLeft), 32'hCAFE);
        check("after_reset_dright", 32'(bus.DRight), 32'h1357);
        check("after_reset_pulse", 32'(valid_cycles), 32'd1);
`ifndef I2S_RX_DEBUG_EN
        check("debug_zero", 32'(dbg_bad), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
